// File: rtl/pdm_pkg.sv
// Shared definitions for the path delay monitor: FSM states and default parameters.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pdm_pkg;

  // Default parameter values for the monitor
  localparam int PDM_CNT_W       = 16;
  localparam int PDM_NUM_TRIALS  = 16;
  localparam int PDM_SETTLE_CYC  = 8;
  localparam int PDM_TIMEOUT_CYC = 1000;

  // Measurement sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CALC   = 3'd3,
    ST_REPORT = 3'd4
  } pdm_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency: 2 clk edges from a stable input to q.
// Backpressure: none; samples every cycle.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Capture the asynchronous input, then re-register to resolve metastability
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/path_delay_monitor.sv
// Launches transitions into a path under test, times each to the synchronized
// output, averages NUM_TRIALS trials and flags deviation from a golden delay.
// Latency: per trial SETTLE_CYC + delay; results 2 cycles after the last trial. No backpressure; start ignored while busy.
module path_delay_monitor
  import pdm_pkg::*;
#(
  parameter int CNT_W       = PDM_CNT_W,
  parameter int NUM_TRIALS  = PDM_NUM_TRIALS,
  parameter int SETTLE_CYC  = PDM_SETTLE_CYC,
  parameter int TIMEOUT_CYC = PDM_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] golden_delay,
  input  logic [CNT_W-1:0] tolerance,
  output logic             launch,
  input  logic             path_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] avg_delay,
  output logic             trojan_flag,
  output logic             timeout_err
);

  // Sum holds NUM_TRIALS delays each below 2^CNT_W, so LOG2_NT extra bits never overflow
  localparam int LOG2_NT = $clog2(NUM_TRIALS);
  localparam int SUM_W   = CNT_W + LOG2_NT;

  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_V   = CNT_W'(TIMEOUT_CYC);
  localparam logic [LOG2_NT-1:0] LAST_TRIAL  = LOG2_NT'(NUM_TRIALS - 1);

  pdm_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [LOG2_NT-1:0] r_trial;
  logic [SUM_W-1:0]   r_sum;
  logic               r_base;
  logic               r_launch;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_avg;
  logic               r_flag;
  logic               r_to;

  logic               w_sync;
  logic               w_switched;
  logic [CNT_W-1:0]   w_avg;
  logic [CNT_W-1:0]   w_diff;
  logic [SUM_W-1:0]   w_sum_next;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (path_out),
    .q     (w_sync)
  );

  // The path has switched once its synchronized output leaves the pre-launch level
  assign w_switched = (w_sync != r_base);

  // Accumulated sum including the trial that just completed
  assign w_sum_next = r_sum + {{LOG2_NT{1'b0}}, r_cnt};

  // Truncating divide by a power of two; a timeout saturates the average
  assign w_avg = r_to ? {CNT_W{1'b1}} : r_sum[SUM_W-1:LOG2_NT];

  // Magnitude of deviation, ordered so the subtraction never wraps
  assign w_diff = (w_avg >= golden_delay) ? (w_avg - golden_delay)
                                          : (golden_delay - w_avg);

  // Measurement sequencer with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_trial  <= '0;
      r_sum    <= '0;
      r_base   <= 1'b0;
      r_launch <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_avg    <= '0;
      r_flag   <= 1'b0;
      r_to     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sum   <= '0;
            r_trial <= '0;
            r_cnt   <= '0;
            r_to    <= 1'b0;
            r_avg   <= '0;
            r_flag  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            // launch keeps its level across trials, so trials alternate polarity
            r_base   <= w_sync;
            r_launch <= ~r_launch;
            r_cnt    <= '0;
            r_state  <= ST_WAIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_WAIT: begin
          if (w_switched) begin
            r_sum <= w_sum_next;
            r_cnt <= '0;
            if (r_trial != LAST_TRIAL) begin
              r_trial <= r_trial + 1'b1;
              r_state <= ST_SETTLE;
            end else begin
              r_state <= ST_CALC;
            end
          end else if (r_cnt == TIMEOUT_V) begin
            // Remaining trials are abandoned once one path fails to switch
            r_to    <= 1'b1;
            r_state <= ST_CALC;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_CALC: begin
          r_avg   <= w_avg;
          r_flag  <= (w_diff > tolerance) | r_to;
          r_done  <= 1'b1;
          r_state <= ST_REPORT;
        end

        ST_REPORT: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign launch      = r_launch;
  assign busy        = r_busy;
  assign done        = r_done;
  assign avg_delay   = r_avg;
  assign trojan_flag = r_flag;
  assign timeout_err = r_to;

endmodule

// File: tb/tb_path_delay_monitor.sv
// Bench for path_delay_monitor: drives modelled paths and compares each result
// against a trial-level reference computed from per-polarity path delays.
// Clock period 10; inputs driven and outputs sampled on the falling edge.
module tb_path_delay_monitor;

  localparam int CW = 16;
  localparam int NT = 16;
  localparam int ST = 8;
  localparam int TO = 1000;
  localparam int BOUND = 20000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] golden_delay = '0;
  logic [CW-1:0] tolerance = '0;
  logic          launch;
  logic          path_out;
  logic          busy;
  logic          done;
  logic [CW-1:0] avg_delay;
  logic          trojan_flag;
  logic          timeout_err;

  int total = 0;
  int bad = 0;

  // Path model: 0 = wire loopback, 1 = rise/fall shift delays, 2 = stuck at 0
  int path_mode = 0;
  int rise_d = 1;
  int fall_d = 1;
  logic [31:0] hist = '0;
  logic exp_lvl = 1'b0;

  always #5 clk = ~clk;

  path_delay_monitor #(
    .CNT_W       (CW),
    .NUM_TRIALS  (NT),
    .SETTLE_CYC  (ST),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .golden_delay (golden_delay),
    .tolerance    (tolerance),
    .launch       (launch),
    .path_out     (path_out),
    .busy         (busy),
    .done         (done),
    .avg_delay    (avg_delay),
    .trojan_flag  (trojan_flag),
    .timeout_err  (timeout_err)
  );

  always @(posedge clk) hist <= {hist[30:0], launch};

  // Rising edges appear rise_d cycles later, falling edges fall_d cycles later
  always_comb begin
    case (path_mode)
      0: path_out = launch;
      1: path_out = (rise_d <= fall_d) ? (hist[rise_d-1] | hist[fall_d-1])
                                        : (hist[rise_d-1] & hist[fall_d-1]);
      default: path_out = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: each trial toggles the launch level; delay = path delay for that
  // polarity plus the two synchronizer edges; a stuck path times out on trial one.
  task automatic model_run(output logic [CW-1:0] e_avg, output logic e_flag, output logic e_to);
    int sum;
    int d;
    int a;
    int g;
    int diff;
    sum  = 0;
    e_to = 1'b0;
    for (int t = 0; t < NT; t++) begin
      exp_lvl = ~exp_lvl;
      if (path_mode == 2) begin
        e_to = 1'b1;
        break;
      end
      if (path_mode == 0) d = 2;
      else d = exp_lvl ? rise_d + 2 : fall_d + 2;
      sum += d;
    end
    e_avg  = e_to ? {CW{1'b1}} : CW'(sum / NT);
    a      = int'(e_avg);
    g      = int'(golden_delay);
    diff   = (a > g) ? a - g : g - a;
    e_flag = e_to || (diff > int'(tolerance));
  endtask

  task automatic measure(input string tag, input bit keep_start, output int lat);
    logic [CW-1:0] e_avg;
    logic e_flag;
    logic e_to;
    logic pl;
    bit   seen;
    int   n;
    model_run(e_avg, e_flag, e_to);
    @(negedge clk);
    start = 1'b1;
    pl    = launch;
    seen  = 0;
    lat   = 0;
    @(negedge clk);
    if (!keep_start) start = 1'b0;
    n = 0;
    while (n < BOUND) begin
      if (seen) lat++;
      else if (launch !== pl) seen = 1;
      if (done === 1'b1) break;
      @(negedge clk);
      n++;
    end
    check({tag, "_done_in_time"}, 32'(n < BOUND), 32'd1);
    check({tag, "_avg"}, 32'(avg_delay), 32'(e_avg));
    check({tag, "_flag"}, 32'(trojan_flag), 32'(e_flag));
    check({tag, "_timeout"}, 32'(timeout_err), 32'(e_to));
    check({tag, "_busy_in_report"}, 32'(busy), 32'd1);
    check({tag, "_launch_level"}, 32'(launch), 32'(exp_lvl));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int toggles;
    int n;
    logic pl;
    logic seen_done;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_launch", 32'(launch), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_avg", 32'(avg_delay), 32'd0);
    check("rst_flag", 32'(trojan_flag), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    exp_lvl = 1'b0;
    repeat (2) @(negedge clk);

    // Direct loopback
    path_mode = 0; golden_delay = 16'd2; tolerance = 16'd0;
    measure("loop", 0, lat);

    // Tolerance boundary: difference equal to tolerance passes, one more fails
    golden_delay = 16'd5; tolerance = 16'd3;
    measure("tol_equal", 0, lat);
    golden_delay = 16'd6; tolerance = 16'd3;
    measure("tol_over", 0, lat);
    // Golden far above the average: a wrapping subtraction would look in-range
    golden_delay = 16'hFFF0; tolerance = 16'd20;
    measure("no_wrap", 0, lat);

    // Five-stage shift-register path
    path_mode = 1; rise_d = 5; fall_d = 5;
    repeat (20) @(negedge clk);
    golden_delay = 16'd7; tolerance = 16'd1;
    measure("shift5_ok", 0, lat);
    golden_delay = 16'd4;
    measure("shift5_bad", 0, lat);

    // Asymmetric rise/fall delays
    rise_d = 5; fall_d = 8; golden_delay = 16'd8; tolerance = 16'd0;
    repeat (20) @(negedge clk);
    measure("asym", 0, lat);

    // Stuck path: timeout on the first trial, done two edges after detection
    path_mode = 2; golden_delay = 16'd2; tolerance = 16'd100;
    measure("stuck", 0, lat);
    check("stuck_done_latency", 32'(lat), 32'(TO + 2));

    // Reset during the wait phase of trial five
    path_mode = 1; rise_d = 5; fall_d = 5;
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pl = launch; toggles = 0; n = 0;
    while (toggles < 5 && n < BOUND) begin
      @(negedge clk);
      n++;
      if (launch !== pl) begin
        toggles++;
        pl = launch;
      end
    end
    check("rstmid_reached_trial5", 32'(toggles), 32'd5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_launch", 32'(launch), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_avg", 32'(avg_delay), 32'd0);
    check("rstmid_flag", 32'(trojan_flag), 32'd0);
    check("rstmid_timeout", 32'(timeout_err), 32'd0);
    exp_lvl = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("rstmid_no_done", 32'(seen_done), 32'd0);
    check("rstmid_idle", 32'(busy), 32'd0);
    golden_delay = 16'd7; tolerance = 16'd1;
    measure("after_rst", 0, lat);

    // start held high: each IDLE acceptance yields one full measurement
    golden_delay = 16'd7; tolerance = 16'd0;
    measure("held_a", 1, lat);
    measure("held_b", 1, lat);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("held_released_idle", 32'(busy), 32'd0);

    // Randomized path delays and thresholds
    for (int r = 0; r < 5; r++) begin
      path_mode    = 1;
      rise_d       = int'($urandom_range(1, 12));
      fall_d       = int'($urandom_range(1, 12));
      golden_delay = CW'($urandom_range(0, 20));
      tolerance    = CW'($urandom_range(0, 4));
      repeat (20) @(negedge clk);
      measure($sformatf("rand%0d", r), 0, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/path_delay_monitor.md
PATH_DELAY_MONITOR -- requirements
Module: path_delay_monitor

Interface
REQ-001 Parameters (name, default, meaning), one per line: CNT_W, 16, delay counter and result width.
REQ-002 NUM_TRIALS, 16, launches per measurement; power of two, at least 2.
REQ-003 SETTLE_CYC, 8, idle cycles before each launch; at least 3.
REQ-004 TIMEOUT_CYC, 1000, maximum cycles to wait per trial; less than 2^CNT_W.
REQ-005 Ports (name, direction, width, meaning), one per line: clk, in, 1, single clock; all logic on rising edge.
REQ-006 rst_n, in, 1, reset, asynchronous and active-low.
REQ-007 start, in, 1, one-cycle request to begin a measurement.
REQ-008 golden_delay, in, CNT_W, expected average delay of a trojan-free path.
REQ-009 tolerance, in, CNT_W, allowed absolute deviation from golden_delay.
REQ-010 launch, out, 1, registered stimulus driving the path-under-test input.
REQ-011 path_out, in, 1, asynchronous output of the path under test.
REQ-012 busy, out, 1, high while a measurement runs.
REQ-013 done, out, 1, one-cycle pulse when results update.
REQ-014 avg_delay, out, CNT_W, averaged trial delay in clk cycles.
REQ-015 trojan_flag, out, 1, measured delay is outside tolerance, or a timeout occurred.
REQ-016 timeout_err, out, 1, a trial exceeded TIMEOUT_CYC.

Function
REQ-017 path_out SHALL pass through a 2-flop synchronizer; the second-flop output is "sync".
REQ-018 The FSM SHALL have the states IDLE, SETTLE, WAIT, CALC and REPORT.
REQ-019 In IDLE, start=1 SHALL clear the sum, the trial index and timeout_err, and go to SETTLE; start outside IDLE SHALL be ignored.
REQ-020 SETTLE SHALL last SETTLE_CYC cycles; on its last edge it SHALL latch sync as the baseline, toggle launch, clear the cycle counter and enter WAIT.
REQ-021 Trial delay SHALL equal the number of clock edges from the launch-toggle edge until sync first differs from the baseline; a direct loopback therefore gives 2.
REQ-022 When sync differs from the baseline in WAIT, the trial delay SHALL be added to the sum.
  - If the trial index is below NUM_TRIALS-1, the index SHALL increment and the FSM SHALL return to SETTLE.
  - Otherwise the FSM SHALL enter CALC.
REQ-023 launch SHALL not be reset between trials, so alternate trials measure rising and falling transitions.
REQ-024 If the counter reaches TIMEOUT_CYC in WAIT, timeout_err SHALL set to 1 and the FSM SHALL go straight to CALC, abandoning the remaining trials.
REQ-025 The sum SHALL be CNT_W+log2(NUM_TRIALS) bits wide and SHALL never overflow.
  - avg_delay = sum >> log2(NUM_TRIALS), truncated.
  - On timeout, avg_delay SHALL be forced to all ones.
REQ-026 CALC SHALL last one cycle and compute the unsigned absolute difference |avg_delay - golden_delay| with no wrap.
  - trojan_flag = (difference > tolerance) OR timeout_err.
  - Difference equal to tolerance SHALL give trojan_flag=0.
REQ-027 REPORT SHALL assert done for exactly one cycle, then return to IDLE.
REQ-028 avg_delay, trojan_flag and timeout_err SHALL hold their values until the next accepted start.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 If sync already differs from the baseline on the first WAIT cycle, the path SHALL be treated as having switched; no special case is applied.

Reset
REQ-031 While rst_n=0, asynchronously and regardless of state:
  - FSM SHALL be IDLE.
  - launch, busy, done, trojan_flag and timeout_err SHALL be 0.
  - avg_delay, sum, counters and the baseline SHALL be 0.
  - Synchronizer flops SHALL be 0.
REQ-032 Reset asserted mid-measurement SHALL abandon it without a done pulse; the first start after release SHALL run a full measurement.

Structure
REQ-033 The FSM state enum and the default parameter constants SHALL live in a shared package, pdm_pkg.
REQ-034 The synchronizer SHALL be a separate sub-module, sync_2ff, with ports clk, rst_n, d and q.

Verification
REQ-035 The bench SHALL cover at least these scenarios:
  - path_out tied to launch, golden=2, tolerance=0 -> avg_delay=2, trojan_flag=0, one done pulse.
  - path modeled as a 5-stage clk shift register, golden=7, tolerance=1 -> avg_delay=7, trojan_flag=0; rerun with golden=4 -> trojan_flag=1.
  - rising edges delayed 5 cycles and falling edges delayed 8 -> avg_delay=(7+10)/2 = 8 (truncated), confirming both polarities alternate.
  - path_out stuck at 0 -> timeout_err=1, trojan_flag=1, avg_delay all ones, done 1 cycle after timeout detection (CALC) plus 1 (REPORT).
  - rst_n pulsed low during WAIT of trial 5 -> all outputs 0 immediately, no done; the next start gives a correct result.
  - start held high through a measurement -> exactly one done pulse per IDLE acceptance; start while busy is ignored.
